// File: rtl/cordic_nco_wrap_if.sv
// Bundle between the NCO wrapper and its host: control, the rotator link and the
// corrected cos/sin stream. The slave modport is the wrapper itself.
interface cordic_nco_wrap_if #(
    parameter int ACC_W = 24
);
    logic                    en;
    logic                    clr;
    logic [ACC_W-1:0]        fcw;
    logic [11:0]             phase_off;
    logic signed [10:0]      z_tgt;
    logic signed [10:0]      x_in;
    logic signed [10:0]      y_in;
    logic signed [10:0]      cos_out;
    logic signed [10:0]      sin_out;
    logic                    out_valid;

    modport master (
        output en, clr, fcw, phase_off, x_in, y_in,
        input  z_tgt, cos_out, sin_out, out_valid
    );

    modport slave (
        input  en, clr, fcw, phase_off, x_in, y_in,
        output z_tgt, cos_out, sin_out, out_valid
    );
endinterface

// File: rtl/cordic_nco_wrap.sv
// Phase accumulator, quadrant fold into the rotator's convergent range, and
// post-rotation sign correction giving full-circle cos/sin.
module cordic_nco_wrap #(
    parameter int ACC_W      = 24,
    parameter int CORDIC_LAT = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    cordic_nco_wrap_if.slave  bus
);
    logic [ACC_W-1:0]        acc_reg;
    logic [11:0]             phase;
    logic                    neg;
    logic                    launch;
    logic signed [10:0]      z_tgt_reg;
    logic signed [10:0]      cos_reg;
    logic signed [10:0]      sin_reg;
    logic signed [10:0]      cos_next;
    logic signed [10:0]      sin_next;
    logic                    out_valid_reg;
    logic [CORDIC_LAT:0]     vld_d_reg;
    logic [CORDIC_LAT:0]     neg_d_reg;
    logic [CORDIC_LAT:0]     vld_d_next;
    logic [CORDIC_LAT:0]     neg_d_next;

    function automatic logic signed [10:0] neg_sat(input logic signed [10:0] v);
        if (v == -11'sd1024) begin
            return 11'sd1023;
        end
        return -v;
    endfunction

    assign phase  = acc_reg[ACC_W-1 -: 12] + bus.phase_off;
    assign launch = bus.en & ~bus.clr;

    // Folding by +-2048 only touches bit 11, so the folded angle is always the
    // low 11 bits; the fold is needed exactly when bits 11 and 10 disagree.
    assign neg = phase[11] ^ phase[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg   <= '0;
            z_tgt_reg <= '0;
        end else begin
            if (bus.clr) begin
                acc_reg <= '0;
            end else if (bus.en) begin
                acc_reg <= acc_reg + bus.fcw;
            end
            if (launch) begin
                z_tgt_reg <= $signed(phase[10:0]);
            end
        end
    end

    assign vld_d_next[0] = launch;
    assign neg_d_next[0] = launch ? neg : neg_d_reg[0];

    generate
        for (genvar gi = 1; gi <= CORDIC_LAT; gi++) begin : g_dly
            assign vld_d_next[gi] = vld_d_reg[gi-1];
            assign neg_d_next[gi] = neg_d_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_d_reg <= '0;
            neg_d_reg <= '0;
        end else begin
            vld_d_reg <= vld_d_next;
            neg_d_reg <= neg_d_next;
        end
    end

    always_comb begin
        cos_next = bus.x_in;
        sin_next = bus.y_in;
        if (neg_d_reg[CORDIC_LAT]) begin
            cos_next = neg_sat(bus.x_in);
            sin_next = neg_sat(bus.y_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cos_reg       <= '0;
            sin_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            cos_reg       <= cos_next;
            sin_reg       <= sin_next;
            out_valid_reg <= vld_d_reg[CORDIC_LAT];
        end
    end

    assign bus.z_tgt     = z_tgt_reg;
    assign bus.cos_out   = cos_reg;
    assign bus.sin_out   = sin_reg;
    assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_cordic_nco_wrap.sv
// Random-stimulus bench for cordic_nco_wrap with an ideal 11-edge rotator model
// and a full-circle trig reference.
module tb_cordic_nco_wrap;
    localparam int  ACC_W = 24;
    localparam int  LAT   = 11;
    localparam real PI    = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   stub = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [ACC_W-1:0] acc_m;
    int               z_m;
    bit               vq[$];
    int               pq[$];

    logic signed [10:0] x_pipe [0:LAT-1];
    logic signed [10:0] y_pipe [0:LAT-1];

    cordic_nco_wrap_if #(.ACC_W(ACC_W)) bus ();

    cordic_nco_wrap #(.ACC_W(ACC_W), .CORDIC_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic signed [10:0] rot(input int z, input bit want_cos);
        real a;
        real r;
        int  v;
        a = real'(z) * PI / 2048.0;
        r = want_cos ? 1023.0 * $cos(a) : 1023.0 * $sin(a);
        v = $rtoi(r + ((r >= 0.0) ? 0.5 : -0.5));
        return 11'(v);
    endfunction

    // Ideal rotator: result appears LAT edges after the angle is presented.
    always @(posedge clk) begin
        x_pipe[0] <= rot(int'(bus.z_tgt), 1'b1);
        y_pipe[0] <= rot(int'(bus.z_tgt), 1'b0);
        for (int i = 1; i < LAT; i++) begin
            x_pipe[i] <= x_pipe[i-1];
            y_pipe[i] <= y_pipe[i-1];
        end
    end

    assign bus.x_in = stub ? -11'sd1024 : x_pipe[LAT-1];
    assign bus.y_in = stub ? -11'sd1024 : y_pipe[LAT-1];

    task automatic chk(input string tag, input int got, input int exp, input int tol);
        checks++;
        if (got - exp > tol || exp - got > tol) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
        end
    endtask

    function automatic void fold(input int p, output int z, output bit n);
        int s;
        s = (p >= 2048) ? p - 4096 : p;
        if (s >= 1024) begin
            z = s - 2048; n = 1'b1;
        end else if (s < -1024) begin
            z = s + 2048; n = 1'b1;
        end else begin
            z = s; n = 1'b0;
        end
    endfunction

    function automatic int ref_trig(input int p, input bit want_cos);
        real a;
        real r;
        a = 2.0 * PI * real'(p) / 4096.0;
        r = want_cos ? 1023.0 * $cos(a) : 1023.0 * $sin(a);
        return $rtoi(r + ((r >= 0.0) ? 0.5 : -0.5));
    endfunction

    task automatic model_reset();
        acc_m = '0;
        z_m   = 0;
        vq.delete();
        pq.delete();
        for (int i = 0; i <= LAT; i++) begin
            vq.push_back(1'b0);
            pq.push_back(0);
        end
    endtask

    task automatic step();
        int p;
        int z;
        int ep;
        bit ev;
        bit n;
        bit launch;
        p = (int'(acc_m[ACC_W-1 -: 12]) + int'(bus.phase_off)) % 4096;
        launch = bus.en && !bus.clr;
        @(posedge clk);
        if (bus.clr) acc_m = '0;
        else if (bus.en) acc_m = acc_m + bus.fcw;
        if (launch) begin
            fold(p, z, n);
            z_m = z;
        end
        vq.push_back(launch);
        pq.push_back(p);
        ev = vq.pop_front();
        ep = pq.pop_front();
        #1;
        chk("z_tgt", int'(bus.z_tgt), z_m, 0);
        chk("out_valid", int'(bus.out_valid), int'(ev), 0);
        if (ev) begin
            fold(ep, z, n);
            if (stub) begin
                chk("cos_stub", int'(bus.cos_out), n ? 1023 : -1024, 0);
                chk("sin_stub", int'(bus.sin_out), n ? 1023 : -1024, 0);
            end else begin
                chk("cos", int'(bus.cos_out), ref_trig(ep, 1'b1), 4);
                chk("sin", int'(bus.sin_out), ref_trig(ep, 1'b0), 4);
            end
            $display("sample p=%0d z=%0d cos=%0d sin=%0d", ep, int'(bus.z_tgt),
                     int'(bus.cos_out), int'(bus.sin_out));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_z_tgt", int'(bus.z_tgt), 0, 0);
        chk("rst_cos", int'(bus.cos_out), 0, 0);
        chk("rst_sin", int'(bus.sin_out), 0, 0);
        chk("rst_valid", int'(bus.out_valid), 0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_const(input int off, input int n);
        bus.phase_off = 12'(off);
        bus.fcw = '0;
        bus.en = 1'b1;
        bus.clr = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [7:0] pat;
        pat = 8'b1101_0011;
        bus.en = 1'b0;
        bus.clr = 1'b0;
        bus.fcw = '0;
        bus.phase_off = '0;
        for (int i = 0; i < LAT; i++) begin
            x_pipe[i] = '0;
            y_pipe[i] = '0;
        end
        @(negedge clk);
        do_reset();

        // Constant phases including the fold boundaries.
        run_const(0, 20);
        run_const(2048, 16);
        run_const(1024, 16);
        run_const(1023, 16);
        run_const(3072, 16);
        run_const(3071, 16);

        // Unit phase step with a gappy en pattern crossing 4095 -> 0.
        bus.fcw = ACC_W'(1) << (ACC_W - 12);
        bus.phase_off = 12'd4090;
        for (int i = 0; i < 64; i++) begin
            bus.en = pat[7 - (i % 8)];
            step();
        end

        // Stub rotator: exercises negate saturation.
        stub = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.en = 1'b1;
            bus.phase_off = 12'($urandom_range(0, 4095));
            bus.fcw = ACC_W'($urandom);
            step();
        end
        stub = 1'b0;

        // clr together with en: accumulator cleared, nothing launched.
        bus.fcw = ACC_W'(24'h123456);
        bus.en = 1'b1;
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;

        for (int i = 0; i < 2500; i++) begin
            if (i == 900 || i == 1700) do_reset();
            stub = (i >= 1200 && i < 1300);
            bus.en  = ($urandom_range(0, 3) != 0);
            bus.clr = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 15) == 0) bus.fcw = ACC_W'($urandom);
            if ($urandom_range(0, 7) == 0) bus.phase_off = 12'($urandom_range(0, 4095));
            step();
        end
        stub = 1'b0;
        bus.en = 1'b0;
        for (int i = 0; i < LAT + 3; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
